// File: rtl/uart_tx_io_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register selects,
// STATUS bit positions and TX FSM encodings.
package uart_tx_io_pkg;

    // Register selects, i.e. addr[3:2] of the TXDATA/STATUS/DIVISOR offsets 0x0/0x4/0x8.
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // A programmed divisor of 0 would stall the baud counter; run it as 1.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/uart_tx_io_fifo.sv
// Small synchronous FIFO; pointers carry one extra MSB so full and empty
// are told apart without a separate counter.
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count = wr_ptr_q - rd_ptr_q;
        rdata = mem_q[rd_ptr_q[AW-1:0]];
        pop_ok  = pop && !empty;
        // A full FIFO still takes a byte when a slot frees on the same edge.
        push_ok = push && (!full || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_io.sv
// IO-bus responder with TXDATA/STATUS/DIVISOR registers, a TX FIFO and an
// 8N1 serialiser (LSB first) driving txd.
module uart_tx_io
    import uart_tx_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wtData,
    output logic [31:0] rdData,
    output logic        txd,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] div_q, div_d;
    logic [15:0] divisor_q, divisor_d;
    logic        ovf_q, ovf_d;

    logic        hit, wr_hit, push, pop, bit_end;
    logic [1:0]  sel;
    logic [7:0]  fifo_rdata;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_count;
    logic [31:0] status;
    logic        unused_bits;

    assign unused_bits = ^{addr[1:0], wtData[31:16]};

    io_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wtData[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Bus decode and register file.
    always_comb begin
        hit    = ce && (addr[31:4] == BASE_ADDR[31:4]);
        sel    = addr[3:2];
        wr_hit = hit && we;
        push   = wr_hit && (sel == REG_TXDATA);
        // A set on the same edge as a W1C clear wins.
        ovf_d  = (push && fifo_full && !pop) || (ovf_q && !(wr_hit && (sel == REG_STATUS) && wtData[ST_OVF]));
        divisor_d = (wr_hit && (sel == REG_DIVISOR)) ? wtData[15:0] : divisor_q;

        status = {23'd0, 5'(fifo_count), ovf_q, fifo_empty, fifo_full, state_q != S_IDLE};
        rdData = 32'd0;
        if (hit && !we) begin
            case (sel)
                REG_STATUS:  rdData = status;
                REG_DIVISOR: rdData = {16'd0, divisor_q};
                default:     rdData = 32'd0;
            endcase
        end
        irq = fifo_empty && (state_q == S_IDLE);
    end

    // TX FSM and baud counter; div_q is latched only at frame start.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        div_d     = div_q;
        pop       = 1'b0;
        bit_end   = (baud_q == div_q - 16'd1);
        baud_d    = (state_q == S_IDLE) ? 16'd0 : (bit_end ? 16'd0 : baud_q + 16'd1);
        txd       = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    div_d   = eff_div(divisor_q);
                    state_d = S_START;
                end
            end
            S_START: begin
                txd = 1'b0;
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                txd = shift_q[0];
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit, no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        div_d   = eff_div(divisor_q);
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            baud_q    <= 16'd0;
            div_q     <= eff_div(DEFAULT_DIV);
            divisor_q <= DEFAULT_DIV;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            baud_q    <= baud_d;
            div_q     <= div_d;
            divisor_q <= divisor_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: doc/uart_tx_io.md
# uart_tx_io

Memory-mapped UART transmitter that sits on the CPU's IO port beside the existing IO block. It decodes the IO-side bus (`ce`/`we`/`addr`/`wtData`/`rdData`) as a responder, buffers written bytes in a small FIFO and serialises them 8N1, LSB first, on `txd`. Software polls STATUS or uses `irq` to pace writes.

## Interface
- `BASE_ADDR`, default 32'h0000_0100: block base address; decode uses `addr[31:4]`.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of 2, range 2..16.
- `DEFAULT_DIV`, default 16'd868: reset value of DIVISOR, in clk cycles per bit.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `ce` input 1: IO chip enable from the CPU.
- `we` input 1: write enable; qualifies a write only when `ce`=1.
- `addr` input 32: byte address.
- `wtData` input 32: write data.
- `rdData` output 32: read data, combinational.
- `txd` output 1: serial line; idles high.
- `irq` output 1: level-high when the FIFO is empty and the FSM is IDLE.

## Operation
- Hit: `ce`=1 and `addr[31:4]`==`BASE_ADDR[31:4]`. Register select is `addr[3:2]`.
- Register 0x0, TXDATA (W): writes `wtData[7:0]` into the FIFO. A read returns 0.
- Register 0x4, STATUS (R/W1C):
  - bit0 busy (FSM not IDLE).
  - bit1 full.
  - bit2 empty.
  - bit3 overflow (sticky).
  - bits[8:4] FIFO count.
  - Writing 1 to bit3 clears overflow; all other bits are read-only.
- Register 0x8, DIVISOR (R/W): `[15:0]`. A value of 0 is treated as 1.
- Register 0xC: reserved. Reads return 0; writes are ignored.
- Reads: `rdData` = selected register when hit and `we`=0, otherwise 32'h0.
- Writes: take effect on the `clk` edge when hit and `we`=1. Non-hit accesses have no effect.
- Push rules:
  - A push is accepted if count<`FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If the FIFO is non-empty: pop into the shift register, latch DIVISOR into `div_q`, go to START.
  - START: `txd`=0 for `div_q` cycles, then go to DATA with `bit_idx`=0.
  - DATA: `txd`=`shift[0]` for `div_q` cycles, then shift right. After `bit_idx`=7, go to STOP.
  - STOP: `txd`=1 for `div_q` cycles.
    - If the FIFO is non-empty: pop, relatch DIVISOR, go to START. There is no idle gap.
    - Otherwise go to IDLE.
- Baud counter: counts 0..`div_q`-1 and wraps at each bit boundary. `div_q` is reloaded from DIVISOR only at frame start, so a DIVISOR write mid-frame affects only the next frame.
- Simultaneous write to TXDATA and an FSM pop: both happen; count is unchanged.
- Simultaneous overflow set and W1C clear: set wins.

## Timing
- Reset values:
  - `txd`=1, `irq`=1, `rdData`=0.
  - FIFO empty; FSM IDLE; counters 0; overflow 0; DIVISOR=`DEFAULT_DIV`.
- Reset mid-frame: `txd` goes to 1 immediately (asynchronous) and any frame in flight is lost.
- Latency, TXDATA write at edge N with the FSM idle:
  - Count becomes 1 after edge N.
  - The pop occurs at edge N+1.
  - `txd` falls after edge N+1.
- Frame length: exactly 10×`div_q` cycles. Back-to-back frames are contiguous.
- `irq` and STATUS reflect registered state and update one edge after the causing event.
- Read path: zero-wait combinational; no handshake and no stall.

## Structure
- Shared constants go into the common define file:
  - register offsets (TXDATA/STATUS/DIVISOR);
  - STATUS bit positions;
  - FSM state encodings (2-bit `localparam`/`define`).
- Sub-module `io_sync_fifo`:
  - Parameterised width/depth; push/pop/full/empty/count.
  - Pointer wrap uses one extra MSB.
  - Asynchronous active-low reset to empty.
- Top-level `uart_tx_io` contains the bus decode, register file, baud counter and TX FSM.

## Test plan
All scenarios use DIVISOR=4 and sample `txd` every cycle.
- Reset then idle: `txd`=1, `irq`=1, STATUS read = 32'h4 (empty). DIVISOR read = 868 before override.
- Write 0x55 to TXDATA: `txd` sequence = 0 ×4, then 1,0,1,0,1,0,1,0 each ×4, then 1 ×4. Total 40 cycles. `irq`=0 during the frame and returns to 1 after STOP.
- Write 0xA5 and 0x3C back-to-back: second start bit begins exactly 40 cycles after the first. No idle cycle between frames.
- FIFO overflow:
  - With the FSM busy, write 9 bytes to an 8-deep FIFO: STATUS shows full=1, overflow=1, count=8, and the 9th byte never appears on `txd`.
  - Write 0x8 to STATUS: overflow becomes 0.
- Push on a full FIFO in the same cycle as a pop: the byte is accepted, count stays 8, overflow stays 0.
- Reset mid-frame, asserting `rst`=0 during DATA: `txd`=1 with no clock edge needed. After release, STATUS reads 32'h4 and DIVISOR reads 868.
